imem_responder: RTL

Instruction-memory responder serving fetch requests from the IF stage. It accepts a fetch PC over a valid/ready handshake and returns the addressed 32-bit instruction after a fixed, parameterised latency. It also returns the originating PC and a fault flag. It supports pipeline flush on branch redirect and has a synchronous load port for program image.

---
 rtl/riscv_pkg.sv | 15 +
 rtl/imem_array.sv | 31 +++
 rtl/imem_responder.sv | 128 ++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared fetch-side definitions: default word width, the canonical NOP
// (addi x0,x0,0) and the fetch FSM state encoding.
package riscv_pkg;

   localparam int WORD_BITWIDTH = 32;

   localparam logic [31:0] NOP_INSTR = 32'h00000013;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/imem_array.sv
// Single-write, single-read synchronous instruction array.
// The read register only updates when rd_en is high, so it doubles as the
// response data holding register. A read and a write to the same index on
// the same edge return the old word (read-before-write).
module imem_array #(
   parameter int WIDTH    = 32,
   parameter int DEPTH    = 256,
   parameter int IDX_BITS = 8
) (
   input  logic                clk,
   input  logic                wr_en,
   input  logic [IDX_BITS-1:0] wr_addr,
   input  logic [WIDTH-1:0]    wr_data,
   input  logic                rd_en,
   input  logic [IDX_BITS-1:0] rd_addr,
   output logic [WIDTH-1:0]    rd_data
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Write port and registered read port; both sample on the same edge.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
      if (rd_en) begin
         rd_data <= mem[rd_addr];
      end
   end

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder for the IF stage. Accepts a fetch PC on a
// valid/ready handshake and returns the instruction, its PC and a fault flag
// a fixed LATENCY cycles later. A flush drops any in-flight fetch.
module imem_responder
   import riscv_pkg::*;
#(
   parameter int                       WORD_BITWIDTH = riscv_pkg::WORD_BITWIDTH,
   parameter int                       DEPTH         = 256,
   parameter int                       ADDR_IDX_BITS = 8,
   parameter int                       LATENCY       = 2,
   parameter logic [WORD_BITWIDTH-1:0] NOP_INSTR     = riscv_pkg::NOP_INSTR
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic [WORD_BITWIDTH-1:0] req_addr,
   input  logic                     flush,
   output logic                     resp_valid,
   input  logic                     resp_ready,
   output logic [WORD_BITWIDTH-1:0] resp_instr,
   output logic [WORD_BITWIDTH-1:0] resp_pc,
   output logic                     resp_fault,
   input  logic                     wr_en,
   input  logic [ADDR_IDX_BITS-1:0] wr_addr,
   input  logic [WORD_BITWIDTH-1:0] wr_data
);

   // Counter preload for BUSY; unused when LATENCY==1 (RESP follows directly).
   localparam logic [3:0] CNT_INIT = 4'(LATENCY - 2);
   // Word-index limit expressed at the width of the PC's word-address field.
   localparam logic [WORD_BITWIDTH-3:0] DEPTH_LIM = (WORD_BITWIDTH-2)'(DEPTH);

   fetch_state_t             state_reg, state_next;
   logic [3:0]               cnt_reg, cnt_next;
   logic                     accept;
   logic                     addr_fault;
   logic                     fault_reg;
   logic                     nop_sel_reg;
   logic [WORD_BITWIDTH-1:0] pc_reg;
   logic [WORD_BITWIDTH-1:0] rd_data;
   logic [ADDR_IDX_BITS-1:0] rd_idx;

   assign rd_idx     = req_addr[ADDR_IDX_BITS+1:2];
   assign addr_fault = (req_addr[1:0] != 2'b00) ||
                       (req_addr[WORD_BITWIDTH-1:2] >= DEPTH_LIM);

   imem_array #(
      .WIDTH    (WORD_BITWIDTH),
      .DEPTH    (DEPTH),
      .IDX_BITS (ADDR_IDX_BITS)
   ) u_array (
      .clk     (clk),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_en   (accept),
      .rd_addr (rd_idx),
      .rd_data (rd_data)
   );

   // Next-state, latency counter and handshake decode; flush overrides all.
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      req_ready  = !flush && ((state_reg == IDLE) ||
                             ((state_reg == RESP) && resp_ready));
      accept     = req_valid && req_ready;

      if (flush) begin
         state_next = IDLE;
      end else if (accept) begin
         if (LATENCY == 1) begin
            state_next = RESP;
         end else begin
            state_next = BUSY;
            cnt_next   = CNT_INIT;
         end
      end else begin
         case (state_reg)
            BUSY: begin
               if (cnt_reg == 4'd0) begin
                  state_next = RESP;
               end else begin
                  cnt_next = cnt_reg - 4'd1;
               end
            end
            RESP: begin
               if (resp_ready) begin
                  state_next = IDLE;
               end
            end
            default: state_next = state_reg;
         endcase
      end
   end

   // FSM state and latency counter registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
         cnt_reg   <= 4'd0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
      end
   end

   // Response side-band capture; NOP selection defaults on at reset so the
   // (unreset) array read register is masked until the first fetch.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_reg      <= '0;
         fault_reg   <= 1'b0;
         nop_sel_reg <= 1'b1;
      end else if (accept) begin
         pc_reg      <= req_addr;
         fault_reg   <= addr_fault;
         nop_sel_reg <= addr_fault;
      end
   end

   assign resp_valid = (state_reg == RESP);
   assign resp_instr = nop_sel_reg ? NOP_INSTR : rd_data;
   assign resp_pc    = pc_reg;
   assign resp_fault = fault_reg;

endmodule
